debounce_edge: RTL

- Conditions a raw, asynchronous, bouncy level input into a clean, synchronous level.
- The clean level drives the d input of the ffd stage directly downstream.
- Also emits single-cycle rise and fall strobes for control logic that needs events rather than levels.
- Internals: N-flop synchronizer, stability counter, 4-state FSM.

---
 rtl/debounce_edge_pkg.sv | 15 +
 rtl/debounce_edge_sync_nff.sv | 25 ++
 rtl/debounce_edge.sv | 110 +++++++++++
 3 files changed

// File: rtl/debounce_edge_pkg.sv
// Shared definitions for input-conditioning blocks:
// debouncer state encodings and default qualification constants.
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 4;

endpackage

// File: rtl/debounce_edge_sync_nff.sv
// N-flop synchronizer with a loadable reset value.
// Plain shift chain, no logic between flops.
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ff_q <= {STAGES{init}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw asynchronous level and emits one-cycle
// rise/fall strobes coincident with the clean level changing.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   STABLE_CNT  = DEF_STABLE_CNT,
    parameter int   CNT_W       = 16,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             din_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .init (INIT_LEVEL),
        .d    (din),
        .q    (din_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (din_s) begin
                    state_d = S_WAIT_H;
                    cnt_d   = ONE;
                end
            end
            S_WAIT_H: begin
                if (!din_s) begin
                    state_d = S_LOW;
                end else if (cnt_q == LAST) begin
                    state_d = S_HIGH;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_HIGH: begin
                if (!din_s) begin
                    state_d = S_WAIT_L;
                    cnt_d   = ONE;
                end
            end
            S_WAIT_L: begin
                if (din_s) begin
                    state_d = S_HIGH;
                end else if (cnt_q == LAST) begin
                    state_d = S_LOW;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        endcase
        // busy tracks the state being entered so it lines up with state_q
        busy_d = (state_d == S_WAIT_H) || (state_d == S_WAIT_L);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT_LEVEL ? S_HIGH : S_LOW;
            cnt_q   <= '0;
            dout_q  <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule
